// File: rtl/seq_pkg.sv
// Shared constants and types for the sequence pattern monitor slice.
package seq_pkg;

    localparam int NIB_W = 4;

    // Default pattern, oldest nibble first.
    localparam logic [NIB_W-1:0] PAT0 = 4'b0001;
    localparam logic [NIB_W-1:0] PAT1 = 4'b0010;
    localparam logic [NIB_W-1:0] PAT2 = 4'b0011;

    // History fill level. One step per valid sample; FULL is terminal until reset.
    typedef enum logic [1:0] {
        FILL_EMPTY = 2'd0,
        FILL_ONE   = 2'd1,
        FILL_TWO   = 2'd2,
        FILL_FULL  = 2'd3
    } fill_state_t;

    // True once two nibbles are held, i.e. an incoming third can complete a pattern.
    function automatic logic fill_ready(input fill_state_t fill);
        return (fill == FILL_TWO) || (fill == FILL_FULL);
    endfunction

endpackage

// File: rtl/seq_history.sv
// Nibble history shift register and fill-level FSM.
// Only the two newest nibbles take part in the compare (the incoming sample is the
// third), so the oldest stage of the 3-deep history is never observable and is not kept.
module seq_history
    import seq_pkg::*;
(
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Valid,
    input  logic [NIB_W-1:0] Number,
    output logic [NIB_W-1:0] h1,
    output logic [NIB_W-1:0] h0,
    output fill_state_t      Fill
);

    fill_state_t      fill_state_r;
    fill_state_t      fill_next_s;
    logic [NIB_W-1:0] h1_r;
    logic [NIB_W-1:0] h0_r;

    // Fill state register; reset returns to EMPTY.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            fill_state_r <= FILL_EMPTY;
        end else begin
            fill_state_r <= fill_next_s;
        end
    end

    // Fill next-state: advance one step per valid sample, saturate at FULL.
    always_comb begin
        fill_next_s = fill_state_r;
        if (Valid) begin
            case (fill_state_r)
                FILL_EMPTY: fill_next_s = FILL_ONE;
                FILL_ONE:   fill_next_s = FILL_TWO;
                FILL_TWO:   fill_next_s = FILL_FULL;
                FILL_FULL:  fill_next_s = FILL_FULL;
                default:    fill_next_s = FILL_EMPTY;
            endcase
        end else begin
            fill_next_s = fill_state_r;
        end
    end

    // History shift on valid samples; holds otherwise.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            h1_r <= {NIB_W{1'b0}};
            h0_r <= {NIB_W{1'b0}};
        end else if (Valid) begin
            h1_r <= h0_r;
            h0_r <= Number;
        end
    end

    assign h1   = h1_r;
    assign h0   = h0_r;
    assign Fill = fill_state_r;

endmodule

// File: rtl/seq_pattern_monitor.sv
// Watches the qualified nibble stream for a 3-nibble pattern (overlap allowed),
// pulses Match per hit, keeps a saturating hit count and the hit-to-hit distance.
module seq_pattern_monitor
    import seq_pkg::*;
#(
    parameter logic [NIB_W-1:0] P0    = PAT0,
    parameter logic [NIB_W-1:0] P1    = PAT1,
    parameter logic [NIB_W-1:0] P2    = PAT2,
    parameter int               CNT_W = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [NIB_W-1:0] Number,
    input  logic             Valid,
    output logic             Match,
    output logic [CNT_W-1:0] MatchCount,
    output logic [CNT_W-1:0] Period,
    output logic             PeriodValid
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [NIB_W-1:0] h1_s;
    logic [NIB_W-1:0] h0_s;
    fill_state_t      fill_s;

    logic             hit_s;
    logic [CNT_W-1:0] since_inc_s;
    logic [CNT_W-1:0] count_inc_s;

    logic             match_r;
    logic [CNT_W-1:0] match_count_r;
    logic [CNT_W-1:0] period_r;
    logic             period_valid_r;
    logic [CNT_W-1:0] since_r;
    logic             hit_seen_r;

    seq_history u_history (
        .CLK    (CLK),
        .Reset  (Reset),
        .Valid  (Valid),
        .Number (Number),
        .h1     (h1_s),
        .h0     (h0_s),
        .Fill   (fill_s)
    );

    // Hit detect on the incoming sample plus saturating increments of both counters.
    always_comb begin
        hit_s       = 1'b0;
        since_inc_s = since_r;
        count_inc_s = match_count_r;
        if (Valid && fill_ready(fill_s) && (h1_s == P0) && (h0_s == P1) && (Number == P2)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        if (since_r != CNT_MAX) begin
            since_inc_s = since_r + CNT_ONE;
        end else begin
            since_inc_s = CNT_MAX;
        end
        if (match_count_r != CNT_MAX) begin
            count_inc_s = match_count_r + CNT_ONE;
        end else begin
            count_inc_s = CNT_MAX;
        end
    end

    // Registered match pulse, hit count, sample distance and period bookkeeping.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            match_r        <= 1'b0;
            match_count_r  <= CNT_ZERO;
            period_r       <= CNT_ZERO;
            period_valid_r <= 1'b0;
            since_r        <= CNT_ZERO;
            hit_seen_r     <= 1'b0;
        end else begin
            match_r <= hit_s;
            if (hit_s) begin
                match_count_r <= count_inc_s;
                // The first hit only starts the distance measurement.
                if (hit_seen_r) begin
                    period_r       <= since_inc_s;
                    period_valid_r <= 1'b1;
                end
                hit_seen_r <= 1'b1;
                since_r    <= CNT_ZERO;
            end else if (Valid) begin
                since_r <= since_inc_s;
            end
        end
    end

    assign Match       = match_r;
    assign MatchCount  = match_count_r;
    assign Period      = period_r;
    assign PeriodValid = period_valid_r;

endmodule

// File: tb/tb_seq_pattern_monitor.sv
// Self-checking bench: three monitor configurations share one stimulus stream and
// are compared every cycle against a sample-index based reference model.
module tb_seq_pattern_monitor;

    logic       clk;
    logic       rst;
    logic       valid;
    logic [3:0] num;

    logic       dmatch [3];
    logic [7:0] dcount [3];
    logic [7:0] dper   [3];
    logic       dpv    [3];
    logic [3:0] cnt2_s;
    logic [3:0] per2_s;

    int checks = 0;
    int errors = 0;

    // Reference model state, one slot per instance.
    logic [3:0] pp0 [3];
    logic [3:0] pp1 [3];
    logic [3:0] pp2 [3];
    int         cmax [3];
    int         m_samp [3];
    logic [3:0] m_prev1 [3];
    logic [3:0] m_prev2 [3];
    int         m_last [3];
    bit         m_seen [3];
    bit         m_match [3];
    int         m_cnt [3];
    int         m_per [3];
    bit         m_pv [3];

    seq_pattern_monitor u_def (
        .CLK(clk), .Reset(rst), .Number(num), .Valid(valid),
        .Match(dmatch[0]), .MatchCount(dcount[0]), .Period(dper[0]), .PeriodValid(dpv[0])
    );

    seq_pattern_monitor #(.P0(4'hA), .P1(4'hA), .P2(4'hA), .CNT_W(8)) u_aaa (
        .CLK(clk), .Reset(rst), .Number(num), .Valid(valid),
        .Match(dmatch[1]), .MatchCount(dcount[1]), .Period(dper[1]), .PeriodValid(dpv[1])
    );

    seq_pattern_monitor #(.P0(4'hA), .P1(4'hA), .P2(4'hA), .CNT_W(4)) u_narrow (
        .CLK(clk), .Reset(rst), .Number(num), .Valid(valid),
        .Match(dmatch[2]), .MatchCount(cnt2_s), .Period(per2_s), .PeriodValid(dpv[2])
    );

    assign dcount[2] = {4'h0, cnt2_s};
    assign dper[2]   = {4'h0, per2_s};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: hits identified from the last two valid samples since reset; period is the
    // difference of valid-sample indices of consecutive hits, clipped at the counter max.
    task automatic model_edge(input bit r, input bit v, input logic [3:0] n);
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                m_samp[k] = 0; m_prev1[k] = 4'h0; m_prev2[k] = 4'h0;
                m_last[k] = 0; m_seen[k] = 1'b0; m_match[k] = 1'b0;
                m_cnt[k] = 0; m_per[k] = 0; m_pv[k] = 1'b0;
            end else begin
                m_match[k] = 1'b0;
                if (v) begin
                    bit hit;
                    hit = (m_samp[k] >= 2) && (m_prev2[k] == pp0[k]) &&
                          (m_prev1[k] == pp1[k]) && (n == pp2[k]);
                    m_samp[k]++;
                    m_prev2[k] = m_prev1[k];
                    m_prev1[k] = n;
                    if (hit) begin
                        m_match[k] = 1'b1;
                        m_cnt[k] = (m_cnt[k] + 1 > cmax[k]) ? cmax[k] : m_cnt[k] + 1;
                        if (m_seen[k]) begin
                            m_per[k] = (m_samp[k] - m_last[k] > cmax[k]) ? cmax[k]
                                                                         : m_samp[k] - m_last[k];
                            m_pv[k] = 1'b1;
                        end
                        m_seen[k] = 1'b1;
                        m_last[k] = m_samp[k];
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("match[%0d]", k), int'(dmatch[k]), int'(m_match[k]));
            check($sformatf("count[%0d]", k), int'(dcount[k]), m_cnt[k]);
            check($sformatf("period[%0d]", k), int'(dper[k]), m_per[k]);
            check($sformatf("pvalid[%0d]", k), int'(dpv[k]), int'(m_pv[k]));
        end
    endtask

    // One clock: drive, clock, advance model, then compare every output.
    task automatic step(input bit r, input bit v, input logic [3:0] n);
        rst = r; valid = v; num = n;
        @(posedge clk);
        model_edge(r, v, n);
        #1;
        compare_all();
    endtask

    task automatic vstep(input logic [3:0] n);
        step(1'b0, 1'b1, n);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 4'h0);
    endtask

    initial begin
        logic [3:0] alpha [5];
        alpha[0] = 4'h0; alpha[1] = 4'h1; alpha[2] = 4'h2; alpha[3] = 4'h3; alpha[4] = 4'hA;
        pp0[0] = 4'h1; pp1[0] = 4'h2; pp2[0] = 4'h3; cmax[0] = 255;
        pp0[1] = 4'hA; pp1[1] = 4'hA; pp2[1] = 4'hA; cmax[1] = 255;
        pp0[2] = 4'hA; pp1[2] = 4'hA; pp2[2] = 4'hA; cmax[2] = 15;
        rst = 1'b1; valid = 1'b0; num = 4'h0;

        // Reset state.
        do_reset();
        do_reset();
        check("rst_match", int'(dmatch[0]), 0);
        check("rst_count", int'(dcount[0]), 0);
        check("rst_pvalid", int'(dpv[0]), 0);

        // 0,1,2,3,4: single pulse right after the 3 is sampled.
        vstep(4'h0); vstep(4'h1); vstep(4'h2);
        check("pre_hit_match", int'(dmatch[0]), 0);
        vstep(4'h3);
        check("hit_match", int'(dmatch[0]), 1);
        check("hit_count", int'(dcount[0]), 1);
        check("hit_pvalid", int'(dpv[0]), 0);
        vstep(4'h4);
        check("pulse_end", int'(dmatch[0]), 0);

        // Two hits five samples apart.
        do_reset();
        vstep(4'h1); vstep(4'h2); vstep(4'h3); vstep(4'h0);
        vstep(4'h0); vstep(4'h1); vstep(4'h2); vstep(4'h3);
        check("per5_period", int'(dper[0]), 5);
        check("per5_pvalid", int'(dpv[0]), 1);
        check("per5_count", int'(dcount[0]), 2);

        // Overlapping A stream.
        do_reset();
        vstep(4'hA); vstep(4'hA); vstep(4'hA);
        check("ovl_m3", int'(dmatch[1]), 1);
        vstep(4'hA);
        check("ovl_m4", int'(dmatch[1]), 1);
        vstep(4'hA);
        check("ovl_m5", int'(dmatch[1]), 1);
        check("ovl_count", int'(dcount[1]), 3);
        check("ovl_period", int'(dper[1]), 1);

        // Valid gap between the 2 and the 3.
        do_reset();
        vstep(4'h1); vstep(4'h2);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h3);
        check("gap_nomatch", int'(dmatch[0]), 0);
        vstep(4'h3);
        check("gap_match", int'(dmatch[0]), 1);
        check("gap_count", int'(dcount[0]), 1);

        // Reset mid-pattern, and reset sharing an edge with a would-be hit.
        do_reset();
        vstep(4'h1); vstep(4'h2);
        do_reset();
        vstep(4'h3);
        check("rstmid_match", int'(dmatch[0]), 0);
        check("rstmid_count", int'(dcount[0]), 0);
        vstep(4'h1); vstep(4'h2); vstep(4'h3);
        check("rstmid_rematch", int'(dmatch[0]), 1);
        check("rstmid_recount", int'(dcount[0]), 1);
        do_reset();
        vstep(4'h1); vstep(4'h2);
        step(1'b1, 1'b1, 4'h3);
        check("rsttie_match", int'(dmatch[0]), 0);
        check("rsttie_count", int'(dcount[0]), 0);

        // Count saturation: 22 A samples give 20 hits.
        do_reset();
        for (int i = 0; i < 22; i++) vstep(4'hA);
        check("sat_count_narrow", int'(dcount[2]), 15);
        check("sat_count_wide", int'(dcount[1]), 20);

        // Period saturation: 40 non-matching samples between two hits.
        do_reset();
        vstep(4'hA); vstep(4'hA); vstep(4'hA);
        for (int i = 0; i < 40; i++) vstep(4'h0);
        vstep(4'hA); vstep(4'hA); vstep(4'hA);
        check("sat_period_narrow", int'(dper[2]), 15);
        check("sat_period_wide", int'(dper[1]), 43);
        check("sat_pvalid", int'(dpv[2]), 1);

        // Randomized stream with valid gaps and occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] n;
            bit         v;
            bit         r;
            if ($urandom_range(0, 9) < 8) n = alpha[$urandom_range(0, 4)];
            else n = 4'($urandom_range(0, 15));
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 199) == 0);
            step(r, v, n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_monitor.md
# seq_pattern_monitor

Downstream consumer of the 4-bit `Number` stream produced by the `Sequence` generator. It watches a qualified nibble stream for a fixed 3-nibble pattern, with overlapping detection allowed. It reports each hit as a one-cycle pulse, keeps a saturating hit count, and measures the distance in valid samples between consecutive hits. It sits between the generator and the board-level status/debug logic.

## Interface
Parameters:
- `P0`, default 4'b0001: first nibble of the pattern (oldest).
- `P1`, default 4'b0010: second nibble of the pattern.
- `P2`, default 4'b0011: third nibble of the pattern (newest).
- `CNT_W`, default 8: width of `MatchCount`, `Period` and the internal sample counter.

Ports:
- `CLK`, in, 1: single clock. All state changes on the rising edge.
- `Reset`, in, 1: synchronous, active-high. Takes priority over every other input.
- `Number`, in, 4: nibble from `Sequence`.
- `Valid`, in, 1: `Number` is sampled only on edges where this is 1.
- `Match`, out, 1: one-cycle pulse per pattern hit.
- `MatchCount`, out, CNT_W: saturating count of hits.
- `Period`, out, CNT_W: valid samples from the previous hit to the latest hit.
- `PeriodValid`, out, 1: `Period` holds a real measurement.

## Operation
- History: a 3-deep shift register `h2,h1,h0` (h0 newest) and a fill counter `Fill` (0..3, saturates at 3).
  - On a `Valid` edge, `h2<=h1`, `h1<=h0`, `h0<=Number`, and `Fill` increments (capped at 3).
  - Without `Valid`, everything holds.
- Fill FSM states: EMPTY(0), ONE(1), TWO(2), FULL(3). Each state advances one step per valid sample. FULL stays in FULL. Only `Reset` returns the FSM to EMPTY.
- Hit condition, evaluated on a `Valid` edge using the incoming sample: `Fill>=2 && h1==P0 && h0==P1 && Number==P2`.
  - The hit is registered, so `Match` is 1 for exactly the cycle after that edge.
- Overlap: no history flush on a hit.
  - With P0=P1=P2=4'hA, the stream A,A,A,A gives hits on samples 3 and 4.
- `MatchCount`: increments on each hit, at the same edge that sets `Match`. It saturates at 2^CNT_W-1 and stays there.
- Sample counter `Since`:
  - Counts valid samples since the last hit.
  - On a hit, `Period<=Since+1` (the current sample is included) and `Since<=0`.
  - Otherwise `Since` increments on valid samples and saturates at 2^CNT_W-1. Saturation is sticky until the next hit, and the saturated value is reported as the `Period`.
- `PeriodValid`: goes 1 on the second hit after reset and stays 1 until reset.
  - The first hit only zeroes `Since` and leaves `Period` at 0.
- Arithmetic is unsigned, CNT_W-bit, with no wrap anywhere (all counters saturate).

## Timing
- Reset values: `Match`=0, `MatchCount`=0, `Period`=0, `PeriodValid`=0, `Fill`=0, history=0, `Since`=0.
- Latency: `Match`, `MatchCount`, `Period` and `PeriodValid` all update one cycle after the edge that samples the third pattern nibble.
- Back-to-back hits (overlap case) give `Match` high on consecutive cycles.
- A gap in `Valid` stretches detection but never breaks it. Pattern nibbles need not arrive on consecutive cycles.
- `Reset` during a partial match discards history; a new match needs three fresh samples.
- If `Reset` and a would-be hit share an edge, `Reset` wins: no pulse and no count.

## Structure
- Package `seq_pkg`: `NIB_W`=4, default pattern constants `PAT0/PAT1/PAT2`, and fill-state encodings `FILL_EMPTY/ONE/TWO/FULL`.
- Sub-module `seq_history`: the shift register plus fill FSM, with outputs `h1`, `h0`, `Fill`.
- The top level holds the compare logic and the three counters.

## Test plan
- Default pattern; after reset, drive 0,1,2,3,4 with `Valid`=1 each cycle -> one `Match` pulse the cycle after sample 3 is clocked in; `MatchCount`=1; `PeriodValid`=0.
- Pattern 1,2,3 repeated, five valid samples apart (1,2,3,0,0,1,2,3) -> second hit gives `Period`=5, `PeriodValid`=1, `MatchCount`=2.
- P0=P1=P2=4'hA; stream A,A,A,A,A -> `Match` high on three consecutive cycles; `MatchCount`=3; `Period`=1.
- Default pattern with `Valid` low for four cycles between the 2 and the 3 -> `Match` still fires once, one cycle after the 3 is sampled.
- Drive 1,2, assert `Reset` for one cycle, then drive 3 -> no `Match`; all outputs 0. Then 1,2,3 -> `Match` and `MatchCount`=1.
- CNT_W=4; 20 back-to-back hits with P0=P1=P2=4'hA -> `MatchCount` stops at 15. Separately, 40 non-matching valid samples between two hits -> `Period`=15.
